// File: rtl/srwpl_seq_ctrl.sv
// Sequencer for an N-bit shift register with parallel load: accepts one word per
// handshake, loads it, shifts it out over N cycles and presents the serial stream.
module srwpl_seq_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_dir,
  input  logic             in_fill,
  output logic [1:0]       sr_sel,
  output logic [N-1:0]     sr_data,
  output logic             sr_i_right,
  output logic             sr_i_left,
  input  logic [N-1:0]     sr_q,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word transfers on any rising edge where in_valid and in_ready are
  // both high; in_ready depends only on registered state, never on in_valid.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     data_q;
  logic             dir_q;
  logic             fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            dir_q  <= in_dir;
            fill_q <= in_fill;
            state  <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced inactive while rst is high, independent of the state register.
  always_comb begin
    in_ready   = 1'b0;
    sr_sel     = SEL_HOLD;
    sr_data    = '0;
    sr_i_right = 1'b0;
    sr_i_left  = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: in_ready = 1'b1;
        LOAD: begin
          sr_sel     = SEL_LOAD;
          sr_data    = data_q;
          sr_i_right = fill_q;
          sr_i_left  = fill_q;
          busy       = 1'b1;
        end
        SHIFT: begin
          sr_sel     = dir_q ? SEL_LEFT : SEL_RIGHT;
          sr_i_right = fill_q;
          sr_i_left  = fill_q;
          ser_valid  = 1'b1;
          busy       = 1'b1;
        end
        default: begin
          done = 1'b1;
          busy = 1'b1;
        end
      endcase
    end
  end

  assign ser_bit   = dir_q ? sr_q[N-1] : sr_q[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_srwpl_seq_ctrl.sv
// Bench for srwpl_seq_ctrl: a behavioural shift register closes the loop; a vector
// table covers reset and two full words, hand sequences cover multi-cycle corners.
module tb_srwpl_seq_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_dir = 1'b0;
  logic       in_fill = 1'b0;
  logic [1:0] sr_sel;
  logic [7:0] sr_data;
  logic       sr_i_right, sr_i_left;
  logic [7:0] sr_q = '0;
  logic       ser_bit, ser_valid, busy, done;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  srwpl_seq_ctrl #(.N(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill),
    .sr_sel(sr_sel), .sr_data(sr_data), .sr_i_right(sr_i_right),
    .sr_i_left(sr_i_left), .sr_q(sr_q), .ser_bit(ser_bit),
    .ser_valid(ser_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural 8-bit shift register driven by the controller
  always_ff @(posedge clk) begin
    case (sr_sel)
      2'b01:   sr_q <= {sr_i_right, sr_q[7:1]};
      2'b10:   sr_q <= {sr_q[6:0], sr_i_left};
      2'b11:   sr_q <= sr_data;
      default: sr_q <= sr_q;
    endcase
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       dir;
    logic       fill;
    logic       e_ready;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic       e_si;
    logic       e_sv;
    logic       e_bit;
    logic       e_busy;
    logic       e_done;
    logic       q_en;
    logic [7:0] e_q;
  } vec_t;

  vec_t tbl[$];

  // scoreboard comparison
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic dr, input logic f, input logic er,
                              input logic [1:0] es, input logic [7:0] ed,
                              input logic esi, input logic esv, input logic eb,
                              input logic ebz, input logic edn,
                              input logic qe, input logic [7:0] eq);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.dir = dr; t.fill = f;
    t.e_ready = er; t.e_sel = es; t.e_data = ed; t.e_si = esi; t.e_sv = esv;
    t.e_bit = eb; t.e_busy = ebz; t.e_done = edn; t.q_en = qe; t.e_q = eq;
    tbl.push_back(t);
  endfunction

  // One word: handshake row, LOAD row, N shift rows (seq gives stream, first bit at [7]), DONE row.
  function automatic void add_word(input logic [7:0] d, input logic dr, input logic f,
                                   input logic [7:0] seq, input logic [7:0] final_q);
    add(0, 1, d, dr, f, 1, 2'b00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 0, 2'b11, d, f, 0, 0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(0, 0, 8'h00, 0, 0, 0, dr ? 2'b10 : 2'b01, 8'h00, f, 1, seq[7-k], 1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 1, 1, 1, final_q);
    add(0, 0, 8'h00, 0, 0, 1, 2'b00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
  endfunction

  task automatic apply_row(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.rst; in_valid = t.valid; in_data = t.data; in_dir = t.dir; in_fill = t.fill;
    #1;
    n_vec++;
    chk($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(t.e_ready));
    chk($sformatf("row%0d sr_sel", idx), 32'(sr_sel), 32'(t.e_sel));
    if (t.rst || t.e_sel == 2'b11)
      chk($sformatf("row%0d sr_data", idx), 32'(sr_data), 32'(t.e_data));
    chk($sformatf("row%0d sr_i_right", idx), 32'(sr_i_right), 32'(t.e_si));
    chk($sformatf("row%0d sr_i_left", idx), 32'(sr_i_left), 32'(t.e_si));
    chk($sformatf("row%0d ser_valid", idx), 32'(ser_valid), 32'(t.e_sv));
    if (t.e_sv) chk($sformatf("row%0d ser_bit", idx), 32'(ser_bit), 32'(t.e_bit));
    chk($sformatf("row%0d busy", idx), 32'(busy), 32'(t.e_busy));
    chk($sformatf("row%0d done", idx), 32'(done), 32'(t.e_done));
    if (t.q_en) chk($sformatf("row%0d sr_q", idx), 32'(sr_q), 32'(t.e_q));
  endtask

  // driver: one cycle with the given inputs, returns after outputs settle
  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic dr, input logic f);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_dir = dr; in_fill = f;
    #1;
  endtask

  // Full word via handshake with checks on LOAD, stream, DONE and final contents.
  task automatic run_word(input string tag, input logic [7:0] d, input logic dr,
                          input logic f, input logic [7:0] seq, input logic [7:0] final_q);
    drive(0, 1, d, dr, f);
    n_vec++;
    chk({tag, " hs ready"}, 32'(in_ready), 32'd1);
    drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk({tag, " load sel"}, 32'(sr_sel), 32'h3);
    chk({tag, " load data"}, 32'(sr_data), 32'(d));
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 8'h00, 0, 0);
      n_vec++;
      chk($sformatf("%s shift%0d sel", tag, k), 32'(sr_sel), dr ? 32'h2 : 32'h1);
      chk($sformatf("%s shift%0d bit", tag, k), 32'(ser_bit), 32'(seq[7-k]));
    end
    drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " final q"}, 32'(sr_q), 32'(final_q));
  endtask

  initial begin
    int hs_cnt, done_cnt, low_cnt;
    int hs_t[2];
    int done_t[2];
    logic saw_done;

    // reset 3 cycles, then idle
    for (int i = 0; i < 3; i++)
      add(1, 1, 8'hFF, 1, 1, 0, 2'b00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++)
      add(0, 0, 8'h00, 0, 0, 1, 2'b00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
    add_word(8'hA5, 1'b0, 1'b0, 8'b1010_0101, 8'h00);
    add_word(8'h3C, 1'b1, 1'b1, 8'b0011_1100, 8'hFF);

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // back-to-back words with in_valid held high
    hs_cnt = 0; done_cnt = 0; low_cnt = 0;
    hs_t[0] = 0; hs_t[1] = 0; done_t[0] = 0; done_t[1] = 0;
    in_valid = 1'b1; in_data = 8'h01; in_dir = 1'b0; in_fill = 1'b0;
    for (int c = 0; c < 40 && !(hs_cnt == 2 && done_cnt == 2); c++) begin
      drive(0, hs_cnt < 2, (hs_cnt == 0) ? 8'h01 : 8'h80, 0, 0);
      if (hs_cnt == 1 && !in_ready) low_cnt++;
      if (in_ready && in_valid) begin
        if (hs_cnt < 2) hs_t[hs_cnt] = c;
        hs_cnt++;
      end
      if (done) begin
        if (done_cnt < 2) done_t[done_cnt] = c;
        done_cnt++;
      end
    end
    n_vec++;
    chk("b2b handshakes", 32'(hs_cnt), 32'd2);
    chk("b2b done pulses", 32'(done_cnt), 32'd2);
    chk("b2b hs spacing", 32'(hs_t[1] - hs_t[0]), 32'd11);
    chk("b2b ready low", 32'(low_cnt), 32'd10);
    chk("b2b done spacing", 32'(done_t[1] - done_t[0]), 32'd11);
    for (int c = 0; c < 12; c++) drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk("b2b idle", 32'(state_dbg), 32'(ST_IDLE));

    // inputs change during SHIFT must not disturb the word
    drive(0, 1, 8'h0F, 0, 0);
    drive(0, 0, 8'hFF, 1, 1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 8'hFF, 1, 1);
      n_vec++;
      chk($sformatf("chg shift%0d sel", k), 32'(sr_sel), 32'h1);
      chk($sformatf("chg shift%0d bit", k), 32'(ser_bit), (k < 4) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk("chg done", 32'(done), 32'd1);
    chk("chg final q", 32'(sr_q), 32'h00);
    drive(0, 0, 8'h00, 0, 0);

    // reset on the 4th SHIFT cycle of 0xF0
    drive(0, 1, 8'hF0, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    n_vec++;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sel", 32'(sr_sel), 32'h0);
    drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst sel after", 32'(sr_sel), 32'h0);
    chk("rst ser_valid", 32'(ser_valid), 32'd0);
    chk("rst ready", 32'(in_ready), 32'd1);
    chk("rst partial q", 32'(sr_q), 32'h1E);
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 8'h00, 0, 0);
      if (done) saw_done = 1'b1;
    end
    n_vec++;
    chk("rst no done", 32'(saw_done), 32'd0);
    run_word("w55", 8'h55, 1'b0, 1'b0, 8'b1010_1010, 8'h00);
    drive(0, 0, 8'h00, 0, 0);
    n_vec++;
    chk("w55 idle ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/srwpl_seq_ctrl.md
Name: srwpl_seq_ctrl

Overview:
- Upstream sequencer for the 8-bit shift register with parallel load.
- Accepts one word at a time over a valid/ready handshake and drives the register's selection, parallel data and serial fill inputs.
- Each accepted word gets one parallel load followed by exactly N shifts in the requested direction.
- Reads the register's output back and presents the outgoing serial bit stream with a valid strobe, plus busy and done status.

Parameters:
- N, 8, word width; must match the shift register width.
- CNT_W, 4, shift counter width; must satisfy 2^CNT_W >= N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  N  word to serialise.
- in_dir  input  1  0 = shift right (LSB out first), 1 = shift left (MSB out first).
- in_fill  input  1  bit shifted into the vacated end during shifting.
- sr_sel  output  2  register selection: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_data  output  N  parallel load value.
- sr_i_right  output  1  serial input consumed by a right shift (enters MSB).
- sr_i_left  output  1  serial input consumed by a left shift (enters LSB).
- sr_q  input  N  current shift register contents.
- ser_bit  output  1  outgoing serial bit.
- ser_valid  output  1  ser_bit is meaningful this cycle.
- busy  output  1  a word is in progress.
- done  output  1  one-cycle pulse after the last shift.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. State register, counter and capture registers are all clocked by clk.
- Reset (rst=1 at an edge):
  - State goes to IDLE; counter and captured data, dir and fill registers clear to 0.
  - While rst is high: in_ready=0, sr_sel=00, sr_data=0, sr_i_right=0, sr_i_left=0, ser_valid=0, busy=0, done=0.
- IDLE:
  - in_ready=1, sr_sel=00, busy=0.
  - If in_valid=1 at an edge, that is the handshake: capture in_data, in_dir and in_fill, then go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - sr_sel=11, sr_data=captured word, busy=1, in_ready=0.
  - Next state SHIFT; counter set to 0.
- SHIFT:
  - sr_sel=01 if captured dir=0, 10 if dir=1. busy=1, ser_valid=1.
  - ser_bit = sr_q[0] when dir=0, sr_q[N-1] when dir=1.
  - Counter increments every cycle. When counter==N-1, go to DONE.
  - Result: exactly N shift cycles.
- DONE:
  - sr_sel=00, done=1, busy=1, ser_valid=0.
  - Next state IDLE unconditionally.
- sr_i_right and sr_i_left both equal the captured fill bit in LOAD and SHIFT; both are 0 in IDLE and DONE.
- Timing, with the handshake edge at cycle t:
  - LOAD occupies cycle t+1.
  - SHIFT occupies cycles t+2 .. t+N+1; the first ser_bit is bit 0 (dir=0) or bit N-1 (dir=1) of the word.
  - done pulses at t+N+2.
  - in_ready is high again at t+N+3.
  - Throughput is one word per N+3 cycles.
- Output paths:
  - All outputs except ser_bit are decoded from registered state only; there is no combinational path from in_* to any output.
  - ser_bit is a combinational mux of sr_q.
- in_valid held high across back-to-back words: the next word is accepted on the first IDLE edge. There is no skid buffer.
- in_data, in_dir and in_fill changes after the handshake have no effect on the word in progress.
- Reset mid-operation:
  - Next edge returns the block to IDLE, sr_sel=00 and no done pulse.
  - The partially shifted register contents are left as-is.
- N=1 is legal: one shift cycle, then DONE.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> in_ready=1, sr_sel=00, busy=0, done=0, ser_valid=0 throughout.
- Right serialise: in_data=8'hA5, dir=0, fill=0, single in_valid pulse -> next cycle sr_sel=11 with sr_data=A5; then 8 cycles of sr_sel=01 with ser_bit sequence 1,0,1,0,0,1,0,1; done high one cycle; final sr_q=00.
- Left serialise with fill: in_data=8'h3C, dir=1, fill=1 -> sr_sel=10 for 8 cycles; ser_bit 0,0,1,1,1,1,0,0; final sr_q=FF; sr_i_left=1 during LOAD and SHIFT.
- Back-to-back words: in_valid held high with 8'h01 then 8'h80 -> second handshake exactly 11 cycles after the first; in_ready low for 10 cycles between them; two done pulses 11 cycles apart.
- Input change mid-word: after accepting 8'h0F, drive in_data=FF and dir=1 during SHIFT -> serial stream still 1,1,1,1,0,0,0,0 and sr_sel stays 01.
- Reset mid-shift: assert rst on the 4th SHIFT cycle of 8'hF0 -> next cycle state IDLE, sr_sel=00, ser_valid=0; no done pulse; after rst drops, in_ready=1 and a new word 8'h55 serialises correctly.
